// File: rtl/risc_pkg.sv
// Shared types for the RISC control path.
// Opcodes, sequencer phases and address width.
package risc_pkg;

  localparam int ADDR_W = 5;

  typedef enum logic [2:0] {
    OP_HLT = 3'd0,
    OP_SKZ = 3'd1,
    OP_ADD = 3'd2,
    OP_AND = 3'd3,
    OP_XOR = 3'd4,
    OP_LDA = 3'd5,
    OP_STO = 3'd6,
    OP_JMP = 3'd7
  } opcode_t;

  typedef enum logic [3:0] {
    INST_ADDR  = 4'd0,
    INST_FETCH = 4'd1,
    INST_LOAD  = 4'd2,
    IDLE       = 4'd3,
    OP_ADDR    = 4'd4,
    OP_FETCH   = 4'd5,
    ALU_OP     = 4'd6,
    STORE      = 4'd7,
    HALTED     = 4'd8
  } phase_t;

  function automatic logic is_aluop(
    input logic [2:0] op
  );
    return (op == OP_ADD) || (op == OP_AND) ||
           (op == OP_XOR) || (op == OP_LDA);
  endfunction

endpackage

// File: rtl/control_sequencer.sv
// Eight-phase instruction sequencer for the RISC core.
// Optional single-step gate: CTRL_SINGLE_STEP_EN.
module control_sequencer
  import risc_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] opcode,
  input  logic       zero,
  output logic       sel,
  output logic       rd,
  output logic       ld_ir,
  output logic       inc_pc,
  output logic       ld_pc,
  output logic       ld_ac,
  output logic       wr,
  output logic       data_e,
  output logic       halt
`ifdef CTRL_SINGLE_STEP_EN
  ,
  input  logic       step
`endif
);

  phase_t phase_q;
  phase_t phase_d;
  logic   go;
  logic   alu;
  logic   is_hlt;
  logic   is_skz;
  logic   is_jmp;
  logic   is_sto;

`ifdef CTRL_SINGLE_STEP_EN
  assign go = step;
`else
  assign go = 1'b1;
`endif

  assign alu    = is_aluop(opcode);
  assign is_hlt = (opcode == OP_HLT);
  assign is_skz = (opcode == OP_SKZ);
  assign is_jmp = (opcode == OP_JMP);
  assign is_sto = (opcode == OP_STO);

  // Phase register; reset aborts any instruction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q <= INST_ADDR;
    end else begin
      phase_q <= phase_d;
    end
  end

  // Next phase; illegal encodings fall back.
  always_comb begin
    phase_d = INST_ADDR;
    unique case (phase_q)
      INST_ADDR:  phase_d = go ? INST_FETCH
                               : INST_ADDR;
      INST_FETCH: phase_d = INST_LOAD;
      INST_LOAD:  phase_d = IDLE;
      IDLE:       phase_d = OP_ADDR;
      OP_ADDR:    phase_d = is_hlt ? HALTED
                                   : OP_FETCH;
      OP_FETCH:   phase_d = ALU_OP;
      ALU_OP:     phase_d = STORE;
      STORE:      phase_d = INST_ADDR;
      HALTED:     phase_d = HALTED;
      default:    phase_d = INST_ADDR;
    endcase
  end

  // Output decode from phase, opcode and zero.
  always_comb begin
    sel    = 1'b0;
    rd     = 1'b0;
    ld_ir  = 1'b0;
    inc_pc = 1'b0;
    ld_pc  = 1'b0;
    ld_ac  = 1'b0;
    wr     = 1'b0;
    data_e = 1'b0;
    halt   = 1'b0;
    unique case (phase_q)
      INST_ADDR: begin
        sel = 1'b1;
      end
      INST_FETCH: begin
        sel = 1'b1;
        rd  = 1'b1;
      end
      INST_LOAD, IDLE: begin
        sel   = 1'b1;
        rd    = 1'b1;
        ld_ir = 1'b1;
      end
      OP_ADDR: begin
        inc_pc = 1'b1;
        halt   = is_hlt;
      end
      OP_FETCH: begin
        rd = alu;
      end
      ALU_OP: begin
        rd     = alu;
        inc_pc = is_skz & zero;
        ld_pc  = is_jmp;
        data_e = is_sto;
      end
      STORE: begin
        rd     = alu;
        ld_ac  = alu;
        ld_pc  = is_jmp;
        wr     = is_sto;
        data_e = is_sto;
      end
      HALTED: begin
        halt = 1'b1;
      end
      default: begin
        sel = 1'b0;
      end
    endcase
  end

endmodule
